child_rr_scheduler: RTL
=======================

// Module: child_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one resource slot among the N_REQ child instances of a
//  hierarchy level (default 5, i.e. inst_0..inst_4). Grants one child at a time and holds
//  the grant until the child signals done, drops its request, or exceeds MAX_HOLD cycles.
//  Sits beside the child instances in the parent module; one instance per level.
// PARAMETERS
//  N_REQ     5    number of requesting children (2..16)
//  MAX_HOLD  16   max cycles a grant may be held before forced release (>=1)
//  ID_W      $clog2(N_REQ)  width of grant index (derived, do not override)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  en           in   1      1 = new grants allowed; 0 = no new grants (current grant runs on)
//  req          in   N_REQ  per-child request, level, held until done or granted-and-released
//  done         in   N_REQ  per-child 1-cycle completion pulse; honoured only for granted child
//  gnt          out  N_REQ  one-hot grant, registered; all-zero when no grant
//  gnt_id       out  ID_W   index of granted child; valid while busy=1
//  busy         out  1      1 while a grant is active (== |gnt)
//  timeout      out  1      1-cycle pulse: grant forcibly released by MAX_HOLD
//  timeout_id   out  ID_W   index of timed-out child; valid with timeout
// BEHAVIOUR
//  Reset: gnt=0, gnt_id=0, busy=0, timeout=0, timeout_id=0, ptr=0, hold_cnt=0, state=IDLE.
//  Reset asserted mid-grant drops gnt immediately (asynchronous); no done/timeout emitted.
//  State machine (all outputs registered):
//   IDLE : if en && |req at edge -> GRANT; winner = first set req at index ptr, ptr+1, ...
//          wrapping N_REQ-1 -> 0. gnt[winner]=1, gnt_id=winner, hold_cnt=0 from next cycle.
//          Latency: req sampled at edge k -> gnt high in cycle k+1.
//   GRANT: hold_cnt increments each cycle (saturating width $clog2(MAX_HOLD+1)).
//          Release at edge when any of: done[gnt_id]=1; req[gnt_id]=0;
//          hold_cnt==MAX_HOLD-1 (timeout). Priority for reporting: done/req-drop beats
//          timeout in the same cycle (timeout not pulsed).
//          On release: gnt=0 next cycle, ptr = (gnt_id+1) mod N_REQ, -> GAP.
//          On timeout: timeout=1, timeout_id=gnt_id during the GAP cycle.
//          done/req changes of non-granted children have no effect on state.
//   GAP  : exactly one cycle with gnt=0 (turnaround). Arbitration evaluated as in IDLE:
//          if en && |req -> GRANT (gnt high cycle after GAP), else -> IDLE.
//  Back-to-back: release decided at edge k -> GAP in k+1 -> next gnt earliest k+2.
//  Fairness: a continuously requesting child waits at most N_REQ-1 grants.
//  en deasserted during GRANT: grant continues to normal release; no new grant until en=1.
//  ptr wrap: after child N_REQ-1 is released ptr=0.
//  MAX_HOLD=1: grant lasts exactly one cycle; timeout pulses unless done/req-drop same cycle.
//  gnt is always one-hot or zero; busy==|gnt; gnt_id holds last value when busy=0.
// TESTING
//  1. rst, en=1, req=5'b00100 at edge 2 -> gnt=00100, gnt_id=2 in cycle 3; done[2] pulse
//     -> gnt=0 one cycle, ptr=3, timeout never set.
//  2. req=5'b11111 held, each child pulses done 2 cycles after grant -> grant order
//     0,1,2,3,4,0; one idle cycle between grants; no timeout.
//  3. MAX_HOLD=16, req[1] held, no done -> gnt[1] high exactly 16 cycles, then gnt=0,
//     timeout=1, timeout_id=1 for one cycle; next grant goes to child 2 if requesting.
//  4. done[3] pulse while child 0 granted -> ignored; gnt unchanged; done and timeout
//     in same cycle -> release without timeout pulse.
//  5. en=0 while child 4 granted, req=5'b11111 -> child 4 released normally, gnt stays 0
//     until en=1, then child 0 granted next cycle (ptr wrapped 4->0).
//  6. rst asserted mid-grant (async, between edges) -> gnt=0, busy=0 immediately; after
//     release grant resumes from ptr=0.

Source files
------------

// File: rtl/child_rr_scheduler.sv
// Round-robin scheduler sharing one resource slot among N_REQ sibling instances.
// One grant at a time, held until done, request drop or MAX_HOLD cycles, then a one-cycle gap.
module child_rr_scheduler #(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 16,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout,
    output logic [ID_W-1:0]  timeout_id
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [HC_W-1:0]     hold_cnt_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [ID_W-1:0]     gnt_id_q;
    logic                busy_q;
    logic                timeout_q;
    logic [ID_W-1:0]     timeout_id_q;

    // Requests rotated so that position 0 is the child currently at the pointer.
    logic [ID_W:0]       rot_sum [N_REQ];
    logic [ID_W-1:0]     rot_idx [N_REQ];
    logic [N_REQ-1:0]    req_rot;
    logic [N_REQ-1:0]    arb_onehot;
    logic                arb_found;
    logic [ID_W-1:0]     arb_idx;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_sum[gi] = {1'b0, ptr_q} + (ID_W+1)'(gi);
            assign rot_idx[gi] = (rot_sum[gi] >= (ID_W+1)'(N_REQ))
                               ? ID_W'(rot_sum[gi] - (ID_W+1)'(N_REQ))
                               : ID_W'(rot_sum[gi]);
            assign req_rot[gi] = req[rot_idx[gi]];
            assign arb_onehot[gi] = (arb_idx == ID_W'(gi));
        end
    endgenerate

    // Scan from the far end so the lowest rotated position wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                arb_found = 1'b1;
                arb_idx   = rot_idx[k];
            end
        end
    end

    logic            cur_done;
    logic            cur_drop;
    logic            hold_expired;
    logic [ID_W-1:0] ptr_after;

    assign cur_done     = done[gnt_id_q];
    assign cur_drop     = ~req[gnt_id_q];
    assign hold_expired = (hold_cnt_q == HC_W'(MAX_HOLD - 1));
    assign ptr_after    = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_GRANT: begin
                    if (cur_done || cur_drop || hold_expired) begin
                        state_q <= S_GAP;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_after;
                        // A normal release in the same cycle suppresses the timeout report.
                        if (!(cur_done || cur_drop)) begin
                            timeout_q    <= 1'b1;
                            timeout_id_q <= gnt_id_q;
                        end
                    end else if (hold_cnt_q != HC_W'(MAX_HOLD)) begin
                        hold_cnt_q <= hold_cnt_q + HC_W'(1);
                    end
                end
                default: begin
                    if (en && arb_found) begin
                        state_q    <= S_GRANT;
                        gnt_q      <= arb_onehot;
                        gnt_id_q   <= arb_idx;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign gnt_id     = gnt_id_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
    assign timeout_id = timeout_id_q;

endmodule
